// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    input  logic                  fifo_read_tx,
    output logic [DATA_WIDTH-1:0] tx_dout_reg,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_next;
    logic                  push;
    logic                  pop;
    logic                  ovf_set;

    // A full FIFO still accepts a write when the same cycle pops the oldest entry.
    assign pop     = !fifo_read_tx && !fifo_empty;
    assign push    = wr_en && (!fifo_full || pop);
    assign ovf_set = wr_en && fifo_full && !pop;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Flush clears occupancy only; the transmitter may still be latching tx_dout_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            tx_dout_reg <= '0;
            fifo_empty  <= 1'b1;
            fifo_full   <= 1'b0;
            overflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                tx_dout_reg <= mem[rd_ptr];
            end
            level      <= level_next;
            fifo_empty <= (level_next == '0);
            fifo_full  <= (level_next == DEPTH_L);
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       fifo_read_tx = 1'b1;
    logic       clr_overflow = 1'b0;
    logic [7:0] tx_dout_reg;
    logic       fifo_empty;
    logic       fifo_full;
    logic [4:0] level;
    logic       overflow;

    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic       rst_chk = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;

    uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .flush(flush),
        .fifo_read_tx(fifo_read_tx),
        .tx_dout_reg(tx_dout_reg),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .level(level),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: status against the model every cycle, popped bytes against the scoreboard.
    always @(negedge clk or posedge rst_chk) begin
        chk("level", int'(level), m_q.size());
        chk("fifo_empty", int'(fifo_empty), int'(m_q.size() == 0));
        chk("fifo_full", int'(fifo_full), int'(m_q.size() == 16));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("tx_dout_hold", int'(tx_dout_reg), int'(m_dout));
        if (exp_q.size() > 0) begin
            chk("pop_data", int'(tx_dout_reg), int'(exp_q.pop_front()));
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic rn,
                        input logic fl, input logic co);
        logic mfull, mp, mpush;
        wr_en = w;
        wr_data = d;
        fifo_read_tx = rn;
        flush = fl;
        clr_overflow = co;
        mfull = (m_q.size() == 16);
        mp    = !rn && (m_q.size() != 0);
        mpush = w && (!mfull || mp);
        @(posedge clk);
        if (fl) begin
            m_q.delete();
        end else begin
            if (mp) begin
                m_dout = m_q.pop_front();
                exp_q.push_back(m_dout);
            end
            if (mpush) m_q.push_back(d);
            if (w && mfull && !mp) m_ovf = 1'b1;
            else if (co) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        wr(8'hA5); idle(); rd(); idle();

        for (int i = 0; i < 16; i++) wr(8'(i));
        idle();
        for (int i = 0; i < 16; i++) begin rd(); idle(); end
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
        idle();

        wr(8'hEE); idle();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); idle();
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1); idle();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); idle();

        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0); idle();
        for (int i = 0; i < 16; i++) begin rd(); idle(); end

        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0); idle();
        rd(); idle();

        for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
        idle();
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0); idle();
        rd(); idle();

        wr(8'h81); wr(8'h82); wr(8'h83); rd(); idle();
        @(negedge clk);
        #1;
        reset = 1'b1;
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_dout = 8'h00;
        #1 rst_chk = 1'b1;
        #1 rst_chk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        wr(8'h9A); idle(); rd(); idle();

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
